// File: rtl/mac_result_drain.sv
// Counts a pass of last-row b beats, snapshots every row accumulator and streams one row per valid/ready beat, then pulses the shared clear.
// First beat 2 cycles after the final b beat; rows hold while i_ready is low. `MAC_RESULT_DRAIN_SAT_EN selects saturation over truncation.
module mac_result_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_ROWS   = 8,
    parameter int VEC_LEN    = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst,
    input  logic                                              i_start,
    input  logic                                              i_last_b_valid,
    input  logic [NUM_ROWS*3*DATA_WIDTH-1:0]                  i_c,
    output logic                                              o_valid,
    input  logic                                              i_ready,
    output logic [OUT_WIDTH-1:0]                              o_data,
    output logic [(NUM_ROWS > 1 ? $clog2(NUM_ROWS) : 1)-1:0]  o_row,
    output logic                                              o_last,
    output logic                                              o_clr,
    output logic                                              o_done,
    output logic                                              o_overrun
);

    localparam int ACC_W = 3 * DATA_WIDTH;
    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(VEC_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        SETTLE,
        DRAIN,
        CLEAR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   beat_cnt;
    logic [ACC_W-1:0]   snap [NUM_ROWS];
    logic [ROW_W-1:0]   row_inc;
    logic               accept;
    logic               late_beat;

    function automatic logic [OUT_WIDTH-1:0] to_out(input logic [ACC_W-1:0] acc);
        logic [OUT_WIDTH-1:0] res;
        res = acc[OUT_WIDTH-1:0];
`ifdef MAC_RESULT_DRAIN_SAT_EN
        if (acc > ACC_W'({OUT_WIDTH{1'b1}})) begin
            res = '1;
        end
`endif
        return res;
    endfunction

    assign accept    = o_valid && i_ready;
    assign row_inc   = o_row + ROW_W'(1);
    assign late_beat = i_last_b_valid && (state == SETTLE || state == DRAIN || state == CLEAR);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = ACCUM;
            ACCUM:   if (i_last_b_valid && beat_cnt == LAST_BEAT) state_nxt = SETTLE;
            SETTLE:  state_nxt = DRAIN;
            DRAIN:   if (accept && o_last) state_nxt = CLEAR;
            CLEAR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_row     <= '0;
            o_last    <= 1'b0;
            o_clr     <= 1'b0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            o_valid <= (state_nxt == DRAIN);
            o_clr   <= (state_nxt == CLEAR);
            o_done  <= (state_nxt == CLEAR);
            if (late_beat) begin
                o_overrun <= 1'b1;
            end
            if (state == ACCUM && i_last_b_valid) begin
                beat_cnt <= (state_nxt == SETTLE) ? '0 : beat_cnt + CNT_W'(1);
            end
            // Row 0 comes straight from i_c because the snapshot loads on this same edge.
            if (state == SETTLE) begin
                o_row  <= '0;
                o_last <= (LAST_ROW == '0);
                o_data <= to_out(i_c[ACC_W-1:0]);
            end else if (state == DRAIN && accept) begin
                if (o_last) begin
                    o_row  <= '0;
                    o_last <= 1'b0;
                    o_data <= '0;
                end else begin
                    o_row  <= row_inc;
                    o_last <= (row_inc == LAST_ROW);
                    o_data <= to_out(snap[row_inc]);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (state == SETTLE) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                snap[r] <= i_c[r*ACC_W +: ACC_W];
            end
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Randomized bench for mac_result_drain against a row-list reference model of the drain.
module tb_mac_result_drain;

    localparam int DW    = 8;
    localparam int NR    = 8;
    localparam int VL    = 8;
    localparam int OW    = 16;
    localparam int AW    = 3 * DW;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_start = 1'b0;
    logic              i_last_b_valid = 1'b0;
    logic [NR*AW-1:0]  i_c = '0;
    logic              o_valid;
    logic              i_ready = 1'b1;
    logic [OW-1:0]     o_data;
    logic [2:0]        o_row;
    logic              o_last;
    logic              o_clr;
    logic              o_done;
    logic              o_overrun;

    mac_result_drain #(
        .DATA_WIDTH (DW),
        .NUM_ROWS   (NR),
        .VEC_LEN    (VL),
        .OUT_WIDTH  (OW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_last_b_valid (i_last_b_valid),
        .i_c            (i_c),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_row          (o_row),
        .o_last         (o_last),
        .o_clr          (o_clr),
        .o_done         (o_done),
        .o_overrun      (o_overrun)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;
    int          ready_mode = 0;
    bit          mon_en   = 1'b0;
    bit          exp_ovr  = 1'b0;
    int unsigned row_val [NR];
    int          got_row [$];
    int          got_dat [$];
    int          got_last [$];
    int          vld_rise_cyc = -1;
    int          clr_cnt = 0, clr_cyc = -1;
    int          done_cnt = 0, done_cyc = -1;
    bit          prev_stall = 1'b0, prev_rst = 1'b1, prev_last = 1'b0;
    logic [OW-1:0] prev_dat = '0;
    logic [2:0]    prev_row = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: a result is the accumulator value clipped or wrapped into OUT_WIDTH bits.
    function automatic int unsigned model_out(input int unsigned acc);
`ifdef MAC_RESULT_DRAIN_SAT_EN
        if (acc >= 65536) return 65535;
`endif
        return acc % 65536;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = (cyc % 3 == 0);
            default: i_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic load_ic();
        for (int r = 0; r < NR; r++) begin
            i_c[r*AW +: AW] = AW'(row_val[r]);
        end
    endtask

    task automatic random_rows();
        for (int r = 0; r < NR; r++) begin
            row_val[r] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 65535) : ($urandom & 32'h00FF_FFFF);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall && !prev_rst && !i_rst) begin
                check_eq("stall_valid", o_valid, 1);
                check_eq("stall_data", o_data, prev_dat);
                check_eq("stall_row", o_row, prev_row);
                check_eq("stall_last", o_last, prev_last);
            end
            if (o_valid && i_ready) begin
                got_row.push_back(int'(o_row));
                got_dat.push_back(int'(o_data));
                got_last.push_back(int'(o_last));
            end
            if (o_valid && vld_rise_cyc < 0) vld_rise_cyc = cyc;
            if (o_clr) begin clr_cnt++; clr_cyc = cyc; end
            if (o_done) begin done_cnt++; done_cyc = cyc; end
        end
        prev_stall = o_valid && !i_ready;
        prev_rst   = i_rst;
        prev_dat   = o_data;
        prev_row   = o_row;
        prev_last  = o_last;
    end

    task automatic run_pass(input int rmode, input bit gaps, input bit restart, input bit inject, input bit b2b);
        int t_last, c0, d0;
        int unsigned exp_dat [NR];
        bit injected;
        t_last = 0;
        ready_mode = rmode;
        got_row.delete(); got_dat.delete(); got_last.delete();
        vld_rise_cyc = -1;
        c0 = clr_cnt;
        d0 = done_cnt;
        for (int r = 0; r < NR; r++) exp_dat[r] = model_out(row_val[r]);
        load_ic();
        i_start = 1'b1; step(); i_start = 1'b0;
        for (int b = 0; b < VL; b++) begin
            if (gaps) repeat ($urandom_range(0, 3)) step();
            if (restart && b == 4) begin
                i_start = 1'b1; step(); i_start = 1'b0;
            end
            t_last = cyc;
            i_last_b_valid = 1'b1; step(); i_last_b_valid = 1'b0;
        end
        step();
        // Past the capture edge: the drained data must ignore this.
        for (int r = 0; r < NR; r++) i_c[r*AW +: AW] = AW'($urandom);
        injected = 1'b0;
        for (int i = 0; i < 400 && clr_cnt == c0; i++) begin
            step();
            if (inject && !injected && o_valid) begin
                i_last_b_valid = 1'b1;
                injected = 1'b1;
                exp_ovr = 1'b1;
            end else begin
                i_last_b_valid = 1'b0;
            end
        end
        i_last_b_valid = 1'b0;
        if (!b2b) begin
            repeat (3) step();
            check_eq("idle_valid", o_valid, 0);
        end
        check_eq("clr_pulses", clr_cnt - c0, 1);
        check_eq("done_pulses", done_cnt - d0, 1);
        check_eq("beat_count", got_row.size(), NR);
        for (int i = 0; i < got_row.size() && i < NR; i++) begin
            check_eq("beat_row", got_row[i], i);
            check_eq("beat_data", got_dat[i], exp_dat[i]);
            check_eq("beat_last", got_last[i], (i == NR - 1) ? 1 : 0);
        end
        if (rmode == 0) begin
            check_eq("first_valid_cyc", vld_rise_cyc, t_last + 2);
            check_eq("clr_cyc", clr_cyc, t_last + 2 + NR);
            check_eq("done_cyc", done_cyc, t_last + 2 + NR);
        end
        check_eq("overrun", o_overrun, exp_ovr);
    endtask

    initial begin
        int c0, d0;
        repeat (3) step();
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_data", o_data, 0);
        check_eq("rst_row", o_row, 0);
        check_eq("rst_last", o_last, 0);
        check_eq("rst_clr", o_clr, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_overrun", o_overrun, 0);
        i_rst = 1'b0;
        mon_en = 1'b1;
        step();

        // Nominal, then the same data under 1,0,0 backpressure.
        for (int k = 0; k < NR; k++) row_val[k] = 100 * k;
        run_pass(0, 0, 0, 0, 0);
        run_pass(1, 0, 0, 0, 0);

        random_rows();
        row_val[3] = 32'h0001_2345;
        run_pass(0, 0, 0, 0, 0);

        // Overrun beat during drain, then a back-to-back gapped pass with a stray start.
        random_rows();
        run_pass(2, 0, 0, 1, 1);
        random_rows();
        run_pass(0, 1, 1, 0, 0);

        for (int p = 0; p < 4; p++) begin
            random_rows();
            run_pass($urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 0, 0);
        end

        // Reset after row 2 is accepted.
        random_rows();
        ready_mode = 0;
        load_ic();
        got_row.delete(); got_dat.delete(); got_last.delete();
        i_start = 1'b1; step(); i_start = 1'b0;
        for (int b = 0; b < VL; b++) begin
            i_last_b_valid = 1'b1; step(); i_last_b_valid = 1'b0;
        end
        for (int i = 0; i < 50 && got_row.size() < 3; i++) step();
        check_eq("rst_mid_row2_seen", got_row.size() >= 3, 1);
        c0 = clr_cnt;
        d0 = done_cnt;
        i_rst = 1'b1;
        step();
        check_eq("mid_rst_valid", o_valid, 0);
        check_eq("mid_rst_data", o_data, 0);
        check_eq("mid_rst_row", o_row, 0);
        check_eq("mid_rst_last", o_last, 0);
        check_eq("mid_rst_clr", o_clr, 0);
        check_eq("mid_rst_done", o_done, 0);
        check_eq("mid_rst_overrun", o_overrun, 0);
        i_rst = 1'b0;
        exp_ovr = 1'b0;
        repeat (12) step();
        check_eq("mid_rst_no_clr", clr_cnt - c0, 0);
        check_eq("mid_rst_no_done", done_cnt - d0, 0);
        check_eq("mid_rst_idle_valid", o_valid, 0);
        random_rows();
        run_pass(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", n_errs, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/mac_result_drain.md
# mac_result_drain

Downstream collector for the chain of `vector_reduce` rows. It counts the valid beats leaving the last row of the chain and waits for the MAC accumulators to settle. It then snapshots every row's accumulator and streams the results out one row per beat over a valid/ready handshake. Once the drain completes, it pulses the clear shared by all rows, so the array is ready for the next vector pass.

## Interface
Parameters:
- `DATA_WIDTH`, 8, operand width of the reducer chain; each row's accumulator is `3*DATA_WIDTH` bits.
- `NUM_ROWS`, 8, number of `vector_reduce` rows in the chain; must be ≥ 1.
- `VEC_LEN`, 8, number of valid b beats per pass; must be ≥ 1.
- `OUT_WIDTH`, 16, width of each streamed result; must be ≤ `3*DATA_WIDTH`.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`, input, 1, clock.
- `i_rst`, input, 1, synchronous active-high reset.
- `i_start`, input, 1, arms a pass; sampled only in IDLE.
- `i_last_b_valid`, input, 1, `o_b_valid` of the last row in the chain.
- `i_c`, input, `NUM_ROWS*3*DATA_WIDTH`, concatenated row accumulators; row 0 is in the LSBs.
- `o_valid`, output, 1, result beat valid.
- `i_ready`, input, 1, consumer accepts the beat.
- `o_data`, output, `OUT_WIDTH`, result for the row given by `o_row`.
- `o_row`, output, `$clog2(NUM_ROWS)` (minimum 1), index of the row being sent.
- `o_last`, output, 1, high on the beat for row `NUM_ROWS-1`.
- `o_clr`, output, 1, one-cycle clear to every row's `i_clr`.
- `o_done`, output, 1, one-cycle pass-complete pulse.
- `o_overrun`, output, 1, sticky error flag.

## Operation
States:
- **IDLE**: accepts `i_start`. Beats arriving in IDLE are ignored. Goes to ACCUM when `i_start` is high.
- **ACCUM**: counts `i_last_b_valid` beats with a `$clog2(VEC_LEN+1)`-bit counter. On the beat where the count reaches `VEC_LEN`, goes to SETTLE.
- **SETTLE**: waits one cycle to cover the MAC's registered accumulate. At exit, captures all of `i_c` into the snapshot register, then goes to DRAIN with the row index at 0.
- **DRAIN**:
  - Holds `o_valid` high.
  - `o_data` is snapshot row `o_row`, reduced to `OUT_WIDTH` bits (see Configuration).
  - Advances the row index on each `o_valid && i_ready`.
  - Goes to CLEAR after the row `NUM_ROWS-1` beat is accepted.
- **CLEAR**: asserts `o_clr` and `o_done` for one cycle, then returns to IDLE.

Rules and boundary conditions:
- `i_start` outside IDLE is ignored.
- An `i_last_b_valid` beat in SETTLE, DRAIN or CLEAR sets `o_overrun`. The beat is not counted and the snapshot is unaffected.
- `o_overrun` clears only on `i_rst`.
- All arithmetic is unsigned.
- The snapshot is immune to changes on `i_c` after capture.

## Timing
- Reset values: `o_valid`=0, `o_data`=0, `o_row`=0, `o_last`=0, `o_clr`=0, `o_done`=0, `o_overrun`=0. State=IDLE, counters=0.
- `i_rst` mid-pass aborts immediately to IDLE; no `o_clr` or `o_done` is issued.
- If the final beat is at cycle t, the state is SETTLE at t+1 and `i_c` is captured at the t+1 edge.
- The first `o_valid` appears at t+2.
- With `i_ready` held high, the DRAIN→CLEAR transition happens on the row `NUM_ROWS-1` beat, which is accepted at t+1+`NUM_ROWS`. `o_clr` and `o_done` are then high in cycle t+2+`NUM_ROWS`.
- While `o_valid && !i_ready`, `o_data`, `o_row` and `o_last` hold stable.
- `o_valid` never drops mid-drain.
- All outputs are registered.
- Back-to-back passes: `i_start` may be high in the cycle after CLEAR (the first IDLE cycle).

## Configuration
- `MAC_RESULT_DRAIN_SAT_EN` defined: `o_data` saturates. Any accumulator value ≥ 2^`OUT_WIDTH` outputs all-ones.
- Macro undefined: `o_data` is the low `OUT_WIDTH` bits of the accumulator (truncation).
- When `OUT_WIDTH == 3*DATA_WIDTH`, both modes behave identically.

## Test plan
All scenarios use default parameters.
- **Nominal pass:** start, 8 beats on consecutive cycles, `i_c` row k = 100·k, `i_ready`=1. Required: 8 beats with data 0,100,…,700 and rows 0..7; `o_last` only on row 7; `o_clr` and `o_done` pulse exactly once, 10 cycles after the final beat.
- **Backpressure:** as nominal, with `i_ready` toggling 1,0,0,1,… Required: each row is presented until accepted; data stays stable while stalled; 8 accepted beats in order.
- **Saturation:** row 3 `i_c` = 0x012345. With the macro defined, row 3 data = 0xFFFF. Without it, row 3 data = 0x2345.
- **Overrun:** send a 9th beat during DRAIN. Required: `o_overrun`=1 and stays 1; drained data unchanged. A following pass completes normally with `o_overrun` still 1.
- **Gapped beats and ignored start:** 8 beats with random gaps, plus `i_start` pulsed again during ACCUM. Required: exactly one drain, starting 2 cycles after the 8th beat.
- **Reset mid-drain:** assert `i_rst` after row 2 is accepted. Required: all outputs at reset values the next cycle; no `o_clr`; a new pass works.
